toggle_handshake_rx: RTL
========================

# toggle_handshake_rx

- Receiving end of the team's two-phase toggle handshake.
- A sender flips `req_tgl` once per word, with `req_data` held stable. This block:
  - synchronizes the toggle,
  - converts each transition into a single capture event,
  - buffers the word in a small FIFO,
  - returns `ack_tgl`, which the sender sees as a toggle it can use to release the next word.
- Buffered words leave on a valid/ready stream toward the local datapath.

## Interface
- `DATA_W`, 8, width of `req_data` / `out_data`
- `DEPTH`, 2, FIFO depth in words; power of two, ≥ 2
- `SYNC_STAGES`, 2, flip-flops in the `req_tgl` synchronizer chain; ≥ 2
- `clk` in 1, single clock; all state updates on the falling edge of `clk`
- `reset` in 1, synchronous, active-high; sampled on the falling edge of `clk`
- `req_tgl` in 1, sender request toggle; asynchronous to `clk`
- `req_data` in DATA_W, bundled data; stable from the `req_tgl` flip until the matching `ack_tgl` flip
- `ack_tgl` out 1, acknowledge toggle; flips once per captured word
- `out_valid` out 1, FIFO non-empty
- `out_data` out DATA_W, head-of-FIFO word
- `out_ready` in 1, consumer accepts the head word when `out_valid` && `out_ready`
- `count` out $clog2(DEPTH)+1, words currently buffered
- `stall` out 1, a transition is pending but the FIFO is full

## Operation
- **Synchronizer:** `sync[0]` samples `req_tgl`; `sync[i]` samples `sync[i-1]`. `req_s = sync[SYNC_STAGES-1]`.
- **Last-seen flag:** register `last` holds the last accepted level of `req_s`.
  - `edge = req_s ^ last`, combinational.
- **Capture:** when `edge` && `count != DEPTH`:
  - write `req_data` at the write pointer,
  - advance the write pointer,
  - `last <= req_s`,
  - `ack_tgl <= ~ack_tgl`.
- **Pending:** when `edge` && `count == DEPTH`, nothing changes and `stall` = 1.
  - `edge` persists because `last` is not updated.
  - The capture happens on the first falling edge where `count < DEPTH` at the start of the cycle.
- **Pop:** when `out_valid` && `out_ready`, the read pointer advances.
- **Count update:**
  - write only → +1
  - pop only → −1
  - write and pop together → unchanged
  - When full, a pop and a pending capture on the same edge are not combined: the pop happens, and the capture waits one edge.
- **Pointers:** wrap modulo `DEPTH`. `count` is never above `DEPTH` and never below 0.
- **Outputs:**
  - `out_valid` = (`count != 0`).
  - `out_data` = `mem[rd_ptr]`. It is meaningful only while `out_valid` = 1 and stays stable while `out_valid` && !`out_ready`.
- **Sender contract:** at most one `req_tgl` flip outstanding, i.e. no second flip before `ack_tgl` flips back. Double flips within the synchronizer window are undetectable, and behaviour under them is undefined.

## Timing
- **Reset values:**
  - `sync` = 0, `last` = 0, `ack_tgl` = 0,
  - pointers = 0, `count` = 0, `out_valid` = 0, `stall` = 0,
  - FIFO storage cleared, so `out_data` = 0.
- **Reset mid-operation:** all buffered words are discarded and any pending transition is dropped.
  - The sender must be reset in the same window so that `req_tgl` = 0.
  - If `req_tgl` = 1 after reset release, one word is captured `SYNC_STAGES`+1 edges later. This is defined behaviour.
- **Latency:** a `req_tgl` flip that is set up before falling edge E0 is captured at edge E0+`SYNC_STAGES` when there is space. Default: E0+2.
  - At that same edge, `ack_tgl` flips, `count` increments, and `out_valid` rises if the FIFO was empty.
- **Throughput:** the round trip is bounded by the sender-side synchronization of `ack_tgl`. Back-to-back captures need at least one edge between them.
- **Pop timing:** a pop at edge E updates `out_data` / `out_valid` after E. There is no combinational path from `out_ready` to `out_valid`.
- **`stall` timing:** combinational from `edge` and `count`. It is high for every cycle that a capture is blocked.

## Test plan
- **Single word:**
  - Stimulus: after reset, `req_data`=0xA5 and `req_tgl` 0→1 before edge 0; `out_ready`=1.
  - Response: `ack_tgl`=1 and `out_valid`=1 with `out_data`=0xA5 after edge 2; `count` returns to 0 after edge 3.
- **Fill and stall:**
  - Stimulus: `out_ready`=0, send 0x11 then 0x22 (each flip after the prior ack); then flip for 0x33.
  - Response: `count`=2; `stall`=1 and `ack_tgl` does not flip.
  - Then raise `out_ready` for one cycle: 0x11 pops, and 0x33 is captured on the following edge with `ack_tgl` flipping.
  - Stream order is 0x11, 0x22, 0x33.
- **Simultaneous write and pop:**
  - Stimulus: `count`=1 holding 0x40, `out_ready`=1, and a capture of 0x41 on the same edge.
  - Response: `count` stays 1 and `out_data`=0x41.
- **Wrap-around:**
  - Stimulus: `DEPTH`=2, send 0x00..0x09 with random `out_ready`.
  - Response: all ten words arrive in order; `count` stays ≤ 2; `ack_tgl` flips exactly 10 times.
- **Reset mid-operation:**
  - Stimulus: with `count`=2 and a pending flip, assert `reset` for one edge with `req_tgl` forced to 0.
  - Response: all outputs return to their reset values and no word appears afterwards.
  - Stimulus: repeat with `req_tgl`=1 held.
  - Response: exactly one capture, `SYNC_STAGES`+1 edges after release.
- **`SYNC_STAGES`=3:**
  - Stimulus: a single flip.
  - Response: `ack_tgl` flips one edge later than in the default build.

Source files
------------

// File: rtl/toggle_handshake_rx.sv
// Receiving end of the two-phase toggle handshake: synchronizes req_tgl, captures
// one word per toggle into a small FIFO, and streams buffered words out on valid/ready.
module toggle_handshake_rx #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_tgl,
    input  logic [DATA_W-1:0]        req_data,
    output logic                     ack_tgl,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     stall
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   last_r;
    logic                   ack_r;
    logic                   valid_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [DATA_W-1:0]      mem_r [DEPTH];

    logic                   req_s;
    logic                   tgl_edge_s;
    logic                   full_s;
    logic                   wr_en_s;
    logic                   rd_en_s;
    logic [CNT_W-1:0]       count_nxt_s;

    assign req_s      = sync_r[SYNC_STAGES-1];
    assign tgl_edge_s = req_s ^ last_r;
    assign full_s     = (count_r == FULL_CNT);
    // Capture is judged on the count at the start of the cycle, so a pop on a full
    // FIFO frees space only for the following edge.
    assign wr_en_s    = tgl_edge_s && !full_s;
    assign rd_en_s    = valid_r && out_ready;

    assign ack_tgl    = ack_r;
    assign out_valid  = valid_r;
    assign out_data   = mem_r[rd_ptr_r];
    assign count      = count_r;
    assign stall      = tgl_edge_s && full_s;

    // Next occupancy from this cycle's write/pop combination.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Toggle synchronizer chain.
    always_ff @(negedge clk) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], req_tgl};
        end
    end

    // Capture, acknowledge and FIFO bookkeeping.
    always_ff @(negedge clk) begin
        if (reset) begin
            last_r   <= 1'b0;
            ack_r    <= 1'b0;
            valid_r  <= 1'b0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= req_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
                last_r          <= req_s;
                ack_r           <= ~ack_r;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != '0);
        end
    end

endmodule
